// File: rtl/vedic_mult_24.sv
// Unsigned 24x24 Urdhva-Tiryagbhyam multiplier with a registered 48-bit product.
// The tree is built 24 -> 12 -> 6 -> 3 bits and uses no '*' operator.
module vedic_mult_24 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic        out_valid,
    output logic [47:0] p
);

    localparam int DATA_W = 24;

    // Base block: explicit column sums; each column's carry ripples into the next.
    function automatic logic [5:0] mul3(input logic [2:0] x, input logic [2:0] y);
        logic [2:0] col1, col2, col3, col4;
        logic [5:0] r;
        r[0] = x[0] & y[0];
        col1 = {2'b00, x[1] & y[0]} + {2'b00, x[0] & y[1]};
        r[1] = col1[0];
        col2 = {2'b00, x[2] & y[0]} + {2'b00, x[1] & y[1]} + {2'b00, x[0] & y[2]}
             + {1'b0, col1[2:1]};
        r[2] = col2[0];
        col3 = {2'b00, x[2] & y[1]} + {2'b00, x[1] & y[2]} + {1'b0, col2[2:1]};
        r[3] = col3[0];
        col4 = {2'b00, x[2] & y[2]} + {1'b0, col3[2:1]};
        r[5:4] = col4[1:0];
        return r;
    endfunction

    // Each level: {HH, LL} plus the (N+1)-bit cross sum shifted up by N/2.
    function automatic logic [11:0] mul6(input logic [5:0] x, input logic [5:0] y);
        logic [5:0]  ll, hl, lh, hh;
        logic [6:0]  mid;
        ll  = mul3(x[2:0], y[2:0]);
        hl  = mul3(x[5:3], y[2:0]);
        lh  = mul3(x[2:0], y[5:3]);
        hh  = mul3(x[5:3], y[5:3]);
        mid = {1'b0, hl} + {1'b0, lh};
        return {hh, ll} + ({5'b0, mid} << 3);
    endfunction

    function automatic logic [23:0] mul12(input logic [11:0] x, input logic [11:0] y);
        logic [11:0] ll, hl, lh, hh;
        logic [12:0] mid;
        ll  = mul6(x[5:0], y[5:0]);
        hl  = mul6(x[11:6], y[5:0]);
        lh  = mul6(x[5:0], y[11:6]);
        hh  = mul6(x[11:6], y[11:6]);
        mid = {1'b0, hl} + {1'b0, lh};
        return {hh, ll} + ({11'b0, mid} << 6);
    endfunction

    function automatic logic [47:0] mul24(input logic [DATA_W-1:0] x,
                                          input logic [DATA_W-1:0] y);
        logic [23:0] ll, hl, lh, hh;
        logic [24:0] mid;
        ll  = mul12(x[11:0], y[11:0]);
        hl  = mul12(x[23:12], y[11:0]);
        lh  = mul12(x[11:0], y[23:12]);
        hh  = mul12(x[23:12], y[23:12]);
        mid = {1'b0, hl} + {1'b0, lh};
        return {hh, ll} + ({23'b0, mid} << 12);
    endfunction

    logic [47:0] prod_p0;
    logic [47:0] prod_p1;
    logic        vld_p1;

    always_comb begin
        prod_p0 = mul24(a, b);
    end

    // Stage p0 -> p1: product register; holds through in_valid gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_p1 <= 48'd0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid)
                prod_p1 <= prod_p0;
        end
    end

    assign p         = prod_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_vedic_mult_24.sv
// Self-checking bench for vedic_mult_24: vector table, random traffic, valid gating, resets.
module tb_vedic_mult_24;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [23:0] a;
    logic [23:0] b;
    logic        out_valid;
    logic [47:0] p;

    int n_cmp;
    int n_bad;

    vedic_mult_24 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] va;
        logic [23:0] vb;
        logic [47:0] exp_p;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [47:0] ref_mul(input logic [23:0] x, input logic [23:0] y);
        logic [47:0] xe, ye;
        xe = {24'd0, x};
        ye = {24'd0, y};
        return xe * ye;
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%012h, expected 0x%012h", name, act, exp_v);
        end
    endtask

    // Drive one operand pair between edges, then sample just after the next rising edge.
    task automatic step(input logic v, input logic [23:0] xa, input logic [23:0] xb);
        @(negedge clk);
        in_valid = v;
        a        = xa;
        b        = xb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] last_p;
        logic [23:0] ra, rb;
        logic        v;

        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{24'd3,       24'd5,       48'd15};
        vecs[1] = '{24'd0,       24'hFFFFFF,  48'd0};
        vecs[2] = '{24'd1,       24'hABCDEF,  48'h000000ABCDEF};
        vecs[3] = '{24'hFFFFFF,  24'hFFFFFF,  48'hFFFFFE000001};
        vecs[4] = '{24'h800000,  24'd2,       48'h000001000000};
        vecs[5] = '{24'h000FFF,  24'h000FFF,  48'h000000FFE001};
        vecs[6] = '{24'hFFF000,  24'h000FFF,  48'h000FFE001000};
        vecs[7] = '{24'hFFFFFF,  24'd1,       48'h000000FFFFFF};

        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 24'h123456;
        b        = 24'h654321;
        repeat (2) @(posedge clk);
        #1;
        check("reset_p", p, 48'd0);
        check("reset_vld", {47'd0, out_valid}, 48'd0);

        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 24'd3, 24'd5);
        check("first_after_reset_p", p, 48'd15);
        check("first_after_reset_vld", {47'd0, out_valid}, 48'd1);

        // Corner vectors, back to back.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vecs[i].va, vecs[i].vb);
            check($sformatf("vec%0d_p", i), p, vecs[i].exp_p);
            check($sformatf("vec%0d_vld", i), {47'd0, out_valid}, 48'd1);
        end

        // Back-to-back random pairs.
        for (int i = 0; i < 100; i++) begin
            ra = 24'($urandom);
            rb = 24'($urandom);
            step(1'b1, ra, rb);
            check($sformatf("rand%0d_p", i), p, ref_mul(ra, rb));
        end

        // Valid gating: out_valid follows in_valid, p holds across gaps.
        last_p = p;
        for (int i = 0; i < 20; i++) begin
            v  = (i % 2) == 0;
            ra = 24'($urandom);
            rb = 24'($urandom);
            step(v, ra, rb);
            if (v)
                last_p = ref_mul(ra, rb);
            check($sformatf("gate%0d_vld", i), {47'd0, out_valid}, {47'd0, v});
            check($sformatf("gate%0d_p", i), p, last_p);
        end

        // Reset asserted mid-stream, between edges.
        for (int i = 0; i < 5; i++) begin
            ra = 24'($urandom) | 24'h800001;
            rb = 24'($urandom) | 24'h800001;
            step(1'b1, ra, rb);
        end
        check("pre_midreset_p", p, ref_mul(ra, rb));
        @(negedge clk);
        in_valid = 1'b1;
        a        = 24'($urandom);
        b        = 24'($urandom);
        rst_n    = 1'b0;
        #1;
        check("midreset_async_p", p, 48'd0);
        check("midreset_async_vld", {47'd0, out_valid}, 48'd0);
        @(posedge clk);
        #1;
        check("midreset_hold_p", p, 48'd0);
        check("midreset_hold_vld", {47'd0, out_valid}, 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ra = 24'($urandom);
        rb = 24'($urandom);
        step(1'b1, ra, rb);
        check("post_midreset_p", p, ref_mul(ra, rb));
        check("post_midreset_vld", {47'd0, out_valid}, 48'd1);
        step(1'b0, 24'hFFFFFF, 24'hFFFFFF);
        check("post_midreset_idle_vld", {47'd0, out_valid}, 48'd0);
        check("post_midreset_idle_p", p, ref_mul(ra, rb));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
